// File: rtl/relu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : relu_seq_pkg
// Purpose  : Shared types and constants for the ReLU sequencer slice:
//            FSM state encoding, default address/count widths and the
//            width of the optional performance counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package relu_seq_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_CNT_WIDTH  = 9;
   localparam int PERF_WIDTH     = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/relu_seq_pipe_valid.sv
`default_nettype none
// ============================================================================
// Module   : relu_seq_pipe_valid
// Purpose  : Two-stage valid shift register tracking rows between the
//            accumulator read, the ReLU register and the buffer write.
//            Both stages freeze while stall is high.
// Ports    : clk, reset (async, active-high)
//            stall     - freeze both stages, gate both enables
//            rd_issue  - a read was issued this cycle (already stall-gated)
//            relu_en   - ReLU register capture enable
//            ub_wr_en  - unified-buffer write enable
// Revision : 1.0 - initial release
// ============================================================================
module relu_seq_pipe_valid (
   input  logic clk,
   input  logic reset,
   input  logic stall,
   input  logic rd_issue,
   output logic relu_en,
   output logic ub_wr_en
);

   logic v1;
   logic v2;

   // Holding the valid bits on stall keeps them aligned with the memory
   // output and ReLU register, which also hold because their enables drop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else if (!stall) begin
         v1 <= rd_issue;
         v2 <= v1;
      end
   end

   assign relu_en  = v1 && !stall;
   assign ub_wr_en = v2 && !stall;

endmodule
`default_nettype wire

// File: rtl/relu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : relu_sequencer
// Purpose  : Streams a block of accumulator rows through the ReLU stage into
//            the unified buffer: accumulator read -> ReLU -> buffer write,
//            one row per cycle, with a global stall.
// Ports    : clk, reset (async, active-high)
//            start, src_base, dst_base, num_rows - command (taken in IDLE)
//            stall                               - freeze all stages
//            busy, done                          - status
//            acc_rd_en/acc_rd_addr               - accumulator read
//            relu_en                             - ReLU register enable
//            ub_wr_en/ub_wr_addr                 - unified-buffer write
//            perf_cycles, perf_stalls            - only with RELU_SEQ_PERF_EN
// Config   : `define RELU_SEQ_PERF_EN adds saturating busy/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module relu_sequencer
   import relu_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_base,
   input  logic [ADDR_WIDTH-1:0] dst_base,
   input  logic [CNT_WIDTH-1:0]  num_rows,
   input  logic                  stall,
   output logic                  busy,
   output logic                  done,
   output logic                  acc_rd_en,
   output logic [ADDR_WIDTH-1:0] acc_rd_addr,
   output logic                  relu_en,
   output logic                  ub_wr_en,
   output logic [ADDR_WIDTH-1:0] ub_wr_addr
`ifdef RELU_SEQ_PERF_EN
   ,
   output logic [PERF_WIDTH-1:0] perf_cycles,
   output logic [PERF_WIDTH-1:0] perf_stalls
`endif
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] src_r;
   logic [ADDR_WIDTH-1:0] dst_r;
   logic [CNT_WIDTH-1:0]  num_r;
   logic [CNT_WIDTH-1:0]  rd_cnt;
   logic [CNT_WIDTH-1:0]  wr_cnt;
   logic [CNT_WIDTH-1:0]  last_idx;

   assign last_idx = num_r - CNT_WIDTH'(1);

   assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
   assign done      = (state == ST_DONE);
   assign acc_rd_en = (state == ST_ISSUE) && !stall;

   // Addresses use only the low bits of the counters so a block may wrap
   // through the top of the address space.
   assign acc_rd_addr = src_r + rd_cnt[ADDR_WIDTH-1:0];
   assign ub_wr_addr  = dst_r + wr_cnt[ADDR_WIDTH-1:0];

   relu_seq_pipe_valid u_pipe_valid (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall),
      .rd_issue (acc_rd_en),
      .relu_en  (relu_en),
      .ub_wr_en (ub_wr_en)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         src_r  <= '0;
         dst_r  <= '0;
         num_r  <= '0;
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  src_r  <= src_base;
                  dst_r  <= dst_base;
                  num_r  <= num_rows;
                  rd_cnt <= '0;
                  wr_cnt <= '0;
                  state  <= (num_rows == '0) ? ST_DONE : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (acc_rd_en) begin
                  rd_cnt <= rd_cnt + CNT_WIDTH'(1);
                  if (rd_cnt == last_idx) begin
                     state <= ST_DRAIN;
                  end
               end
               if (ub_wr_en) begin
                  wr_cnt <= wr_cnt + CNT_WIDTH'(1);
               end
            end
            ST_DRAIN: begin
               if (ub_wr_en) begin
                  wr_cnt <= wr_cnt + CNT_WIDTH'(1);
                  if (wr_cnt == last_idx) begin
                     state <= ST_DONE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef RELU_SEQ_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else if ((state == ST_IDLE) && start) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else begin
         if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + PERF_WIDTH'(1);
         end
         if (busy && stall && (perf_stalls != '1)) begin
            perf_stalls <= perf_stalls + PERF_WIDTH'(1);
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/relu_sequencer.md
Name: relu_sequencer

Overview:
- Controller that streams a block of accumulator rows through the vector ReLU stage and into the unified buffer.
- Sits between the systolic-array accumulator memory (synchronous read, 1-cycle latency) and the unified buffer.
- Sequences three stages: accumulator read enable, ReLU enable, and buffer write enable with write address.
- One command (src base, dst base, row count) is accepted at a time; a global stall freezes the whole pipeline.

Parameters:
- ADDR_WIDTH, 8, width of accumulator and unified-buffer row addresses.
- CNT_WIDTH, 9, width of the row-count field (allows 0..2^ADDR_WIDTH rows).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- src_base  in  ADDR_WIDTH  first accumulator row
- dst_base  in  ADDR_WIDTH  first unified-buffer row
- num_rows  in  CNT_WIDTH  rows to process
- stall  in  1  freezes all stages while high
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- acc_rd_en  out  1  accumulator read enable
- acc_rd_addr  out  ADDR_WIDTH  accumulator read address
- relu_en  out  1  enable to the ReLU vector register stage
- ub_wr_en  out  1  unified-buffer write enable
- ub_wr_addr  out  ADDR_WIDTH  unified-buffer write address

Behaviour:
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE transitions:
  - start=1 and num_rows>0 -> ISSUE; latch src_base, dst_base and num_rows.
  - start=1 and num_rows=0 -> DONE; no enables are ever asserted.
- ISSUE: acc_rd_en = !stall. acc_rd_addr = src_base + rd_cnt, modulo 2^ADDR_WIDTH (wraps silently). rd_cnt increments on each issued read. When the last read is issued -> DRAIN.
- Pipeline valid bits:
  - v1 is set the cycle after an issued read.
  - v2 is set the cycle after relu_en.
  - relu_en = v1 && !stall.
  - ub_wr_en = v2 && !stall.
  - ub_wr_addr = dst_base + wr_cnt, modulo 2^ADDR_WIDTH. wr_cnt increments on each write.
- Stall: while stall=1, all three enables are low and rd_cnt, wr_cnt, v1, v2 and the FSM hold. The memory output and the ReLU output register retain their data because their enables are low, so no row is lost or duplicated.
- DRAIN: the FSM moves to DONE on the cycle the write with wr_cnt = num_rows-1 occurs.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = 1 in ISSUE and DRAIN; 0 in IDLE and DONE.
- start while not in IDLE is ignored (no queuing).
- Latency, no stall, start sampled at edge 0:
  - first acc_rd_en in cycle 1
  - first relu_en in cycle 2
  - first ub_wr_en in cycle 3
  - last write in cycle N+2
  - done in cycle N+3
  - throughput is 1 row/cycle.
- Reset (any time, including mid-command):
  - FSM returns to IDLE.
  - All counters and valid bits clear.
  - busy, done, acc_rd_en, relu_en, ub_wr_en and both addresses are 0.
  - In-flight rows are discarded.
- num_rows = 2^ADDR_WIDTH: every row is processed once; addresses wrap through the full space.

Optional Feature:
- Macro RELU_SEQ_PERF_EN.
- When defined, two outputs are added, both cleared by reset and at each accepted start:
  - perf_cycles (32): counts cycles with busy=1.
  - perf_stalls (32): counts cycles with busy=1 and stall=1.
  - Both saturate at all-ones.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package relu_seq_pkg holds:
  - the state enum type (IDLE/ISSUE/DRAIN/DONE)
  - default ADDR_WIDTH and CNT_WIDTH constants
  - the perf counter width constant (32).
- One natural sub-module, relu_seq_pipe_valid: a two-stage valid-bit shift register with hold-on-stall, producing relu_en and ub_wr_en.
- The FSM and counters stay in the top module.

Test Plan:
- Basic run: src=0x10, dst=0x80, N=4, no stall.
  - Reads at 0x10..0x13 in cycles 1-4; relu_en in cycles 2-5.
  - Writes at 0x80..0x83 in cycles 3-6; done=1 only in cycle 7; busy=1 in cycles 1-6.
- Zero length: start with N=0 -> done pulse in cycle 1; busy and all enables stay 0.
- Stall mid-stream: N=3, stall=1 in cycles 3-4 -> no enables in cycles 3-4.
  - Writes occur at dst+0..2 exactly once each, in cycles 5-7; done in cycle 8.
  - A bench with a ReLU model and a memory model confirms the written data equals max(0, acc row).
- Address wrap: src=0xFE, dst=0xFF, N=3 -> read addresses 0xFE, 0xFF, 0x00; write addresses 0xFF, 0x00, 0x01.
- Ignored start and mid-command reset: a second start in cycle 2 of an N=5 run has no effect. Asserting reset in cycle 4 drives all outputs to 0 immediately; a later start with N=1 runs normally with done in cycle 4.
- With RELU_SEQ_PERF_EN: the stall-mid-stream case yields perf_cycles=7 and perf_stalls=2.
